tcp_option_decoder: RTL and testbench

Receive-side counterpart of the TCP option encoder: it sits directly downstream of the TCP header word stream and parses the 32-bit options words of a received segment into the encoder's field format (option bitmap, MSS, window scale, SACK blocks, timestamps). It parses byte-serially (kind/length/data), so options may straddle word boundaries. When the options field has been fully parsed it reports completion and any malformation.

---
 rtl/tcp_option_decoder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_tcp_option_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tcp_option_decoder.sv
// tcp_option_decoder: byte-serial parser for the TCP options words of a received
// segment. Each accepted 32-bit word is consumed one byte per clock (kind, length,
// data), so options may straddle word boundaries. Parsed fields are presented in
// the same format the option encoder consumes, and done/error report completion.
module tcp_option_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [3:0]  opt_words,
    input  logic [31:0] data_option,
    output logic        ready,
    output logic [8:0]  option_av,
    output logic [15:0] mss,
    output logic [7:0]  scale_wnd,
    output logic [2:0]  sack_nbr,
    output logic [63:0] sack_n0,
    output logic [63:0] sack_n1,
    output logic [63:0] sack_n2,
    output logic [63:0] sack_n3,
    output logic [63:0] time_stp,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        KIND,
        LEN,
        DATA,
        PAD,
        ERR
    } parse_state_t;

    parse_state_t state;
    parse_state_t state_next;

    logic [31:0]  word_buf;
    logic         buf_full;
    logic [1:0]   bidx;
    logic [5:0]   bytes_left;
    logic [7:0]   kind;
    logic [7:0]   opt_len;
    logic [7:0]   data_left;
    logic [247:0] shift_reg;
    logic [255:0] shift_next;
    logic         done_pend;

    logic         accept;
    logic         restart;
    logic         bad_count;
    logic         process;
    logic         last_byte;
    logic [7:0]   cur_byte;
    logic [7:0]   avail;
    logic         len_bad;
    logic [2:0]   sack_count;
    logic [8:0]   av_set;
    logic         err_set;
    logic         commit;

    // A new word may be loaded when the buffer is empty or its last byte is being consumed.
    assign ready      = !buf_full || (bidx == 2'd3);
    assign accept     = enable && ready;
    assign restart    = accept && start;
    assign bad_count  = (opt_words == 4'd0) || (opt_words > 4'd10);
    assign process    = buf_full;
    assign last_byte  = process && (bytes_left == 6'd1);
    assign shift_next = {shift_reg, cur_byte};

    // Select the byte of the buffered word currently being parsed (network order).
    always_comb begin
        case (bidx)
            2'd0:    cur_byte = word_buf[31:24];
            2'd1:    cur_byte = word_buf[23:16];
            2'd2:    cur_byte = word_buf[15:8];
            default: cur_byte = word_buf[7:0];
        endcase
    end

    // Validate a length byte against the bytes left in the segment and the option kind.
    always_comb begin
        avail   = {2'b00, bytes_left} + 8'd1;
        len_bad = (cur_byte < 8'd2) || (cur_byte > avail);
        case (kind)
            8'd2:    if (cur_byte != 8'd4)  len_bad = 1'b1;
            8'd3:    if (cur_byte != 8'd3)  len_bad = 1'b1;
            8'd4:    if (cur_byte != 8'd2)  len_bad = 1'b1;
            8'd8:    if (cur_byte != 8'd10) len_bad = 1'b1;
            8'd5:    if (!((cur_byte == 8'd10) || (cur_byte == 8'd18) ||
                           (cur_byte == 8'd26) || (cur_byte == 8'd34))) len_bad = 1'b1;
            default: ;
        endcase
    end

    // Number of SACK blocks implied by the stored SACK option length.
    always_comb begin
        case (opt_len)
            8'd10:   sack_count = 3'd1;
            8'd18:   sack_count = 3'd2;
            8'd26:   sack_count = 3'd3;
            8'd34:   sack_count = 3'd4;
            default: sack_count = 3'd0;
        endcase
    end

    // Parser next-state and per-byte control decisions.
    always_comb begin
        state_next = state;
        av_set     = '0;
        err_set    = 1'b0;
        commit     = 1'b0;
        if (process) begin
            case (state)
                KIND: begin
                    if (cur_byte == 8'd0) begin
                        av_set     = 9'd1;
                        state_next = PAD;
                    end else if (cur_byte == 8'd1) begin
                        av_set = 9'd2;
                    end else begin
                        state_next = LEN;
                    end
                end
                LEN: begin
                    if (len_bad) begin
                        err_set    = 1'b1;
                        state_next = ERR;
                    end else if (cur_byte == 8'd2) begin
                        state_next = KIND;
                        if (kind <= 8'd8) av_set = 9'd1 << kind[3:0];
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (data_left == 8'd1) begin
                        commit     = 1'b1;
                        state_next = KIND;
                        if (kind <= 8'd8) av_set = 9'd1 << kind[3:0];
                    end
                end
                default: ;
            endcase
            if (last_byte) begin
                if ((state_next == LEN) || (state_next == DATA)) err_set = 1'b1;
                state_next = IDLE;
            end
        end
        if (restart) state_next = bad_count ? IDLE : KIND;
    end

    // Parser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Word buffer, byte bookkeeping, field commits and completion reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_buf   <= '0;
            buf_full   <= 1'b0;
            bidx       <= 2'd0;
            bytes_left <= 6'd0;
            kind       <= 8'd0;
            opt_len    <= 8'd0;
            data_left  <= 8'd0;
            shift_reg  <= '0;
            done_pend  <= 1'b0;
            option_av  <= '0;
            mss        <= '0;
            scale_wnd  <= '0;
            sack_nbr   <= '0;
            sack_n0    <= '0;
            sack_n1    <= '0;
            sack_n2    <= '0;
            sack_n3    <= '0;
            time_stp   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (process) begin
                bidx       <= bidx + 2'd1;
                bytes_left <= bytes_left - 6'd1;
                shift_reg  <= shift_next[247:0];
                if (bidx == 2'd3) buf_full <= 1'b0;
                if (state == KIND) kind <= cur_byte;
                if (state == LEN) begin
                    opt_len   <= cur_byte;
                    data_left <= cur_byte - 8'd2;
                end
                if (state == DATA) data_left <= data_left - 8'd1;
                option_av <= option_av | av_set;
                if (err_set) error <= 1'b1;
                if (commit) begin
                    case (kind)
                        8'd2: mss       <= shift_next[15:0];
                        8'd3: scale_wnd <= shift_next[7:0];
                        8'd8: time_stp  <= shift_next[63:0];
                        8'd5: begin
                            sack_nbr <= sack_count;
                            sack_n0  <= '0;
                            sack_n1  <= '0;
                            sack_n2  <= '0;
                            sack_n3  <= '0;
                            case (sack_count)
                                3'd1: sack_n0 <= shift_next[63:0];
                                3'd2: begin
                                    sack_n0 <= shift_next[127:64];
                                    sack_n1 <= shift_next[63:0];
                                end
                                3'd3: begin
                                    sack_n0 <= shift_next[191:128];
                                    sack_n1 <= shift_next[127:64];
                                    sack_n2 <= shift_next[63:0];
                                end
                                3'd4: begin
                                    sack_n0 <= shift_next[255:192];
                                    sack_n1 <= shift_next[191:128];
                                    sack_n2 <= shift_next[127:64];
                                    sack_n3 <= shift_next[63:0];
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                if (last_byte) done <= 1'b1;
            end
            if (done_pend) begin
                done      <= 1'b1;
                done_pend <= 1'b0;
            end
            if (accept) begin
                if (start) begin
                    option_av <= '0;
                    mss       <= '0;
                    scale_wnd <= '0;
                    sack_nbr  <= '0;
                    sack_n0   <= '0;
                    sack_n1   <= '0;
                    sack_n2   <= '0;
                    sack_n3   <= '0;
                    time_stp  <= '0;
                    done      <= 1'b0;
                    error     <= bad_count;
                    done_pend <= bad_count;
                    if (bad_count) begin
                        buf_full <= 1'b0;
                    end else begin
                        word_buf   <= data_option;
                        buf_full   <= 1'b1;
                        bidx       <= 2'd0;
                        bytes_left <= {opt_words, 2'b00};
                    end
                end else if (state_next != IDLE) begin
                    word_buf <= data_option;
                    buf_full <= 1'b1;
                    bidx     <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tcp_option_decoder.sv
// tb_tcp_option_decoder: directed scenarios for the TCP option decoder with a
// queue of expected segment results checked whenever done is reported.
module tb_tcp_option_decoder;

    typedef struct {
        logic [8:0]  av;
        logic [15:0] mss;
        logic [7:0]  scale;
        logic [2:0]  nbr;
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
        logic [63:0] ts;
        logic        err;
        int          lat;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [3:0]  opt_words;
    logic [31:0] data_option;
    logic        ready;
    logic [8:0]  option_av;
    logic [15:0] mss;
    logic [7:0]  scale_wnd;
    logic [2:0]  sack_nbr;
    logic [63:0] sack_n0, sack_n1, sack_n2, sack_n3;
    logic [63:0] time_stp;
    logic        done;
    logic        error;

    expect_t     sb[$];
    logic [31:0] stim[16];
    int          cyc = 0;
    int          e0 = 0;
    int          compared = 0;
    int          mismatched = 0;

    tcp_option_decoder dut (
        .clk(clk), .reset(rst_n), .enable(enable), .start(start),
        .opt_words(opt_words), .data_option(data_option), .ready(ready),
        .option_av(option_av), .mss(mss), .scale_wnd(scale_wnd), .sack_nbr(sack_nbr),
        .sack_n0(sack_n0), .sack_n1(sack_n1), .sack_n2(sack_n2), .sack_n3(sack_n3),
        .time_stp(time_stp), .done(done), .error(error)
    );

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic expect_t mkExp(input logic [8:0] av, input logic [15:0] m,
                                      input logic [7:0] sc, input logic [2:0] nb,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c, input logic [63:0] d,
                                      input logic [63:0] ts, input logic err, input int lat);
        expect_t e;
        e.av = av; e.mss = m; e.scale = sc; e.nbr = nb;
        e.s0 = a; e.s1 = b; e.s2 = c; e.s3 = d;
        e.ts = ts; e.err = err; e.lat = lat;
        return e;
    endfunction

    // Drive the first n_send words of stim[] as one segment, holding enable high.
    task automatic applyStimulus(input logic [3:0] ow, input int n_send, input bit push,
                                 input expect_t exp);
        int i = 0;
        int guard = 0;
        while (i < n_send && guard < 300) begin
            @(negedge clk);
            enable      = 1'b1;
            start       = (i == 0);
            opt_words   = ow;
            data_option = stim[i];
            if (ready) begin
                if (i == 0) e0 = cyc + 1;
                i++;
            end
            guard++;
        end
        @(negedge clk);
        enable = 1'b0;
        start  = 1'b0;
        if (i < n_send) compare("accept_timeout", 64'(i), 64'(n_send));
        if (push) sb.push_back(exp);
    endtask

    // Wait (bounded) for done, then compare every field against the oldest expectation.
    task automatic checkOutput(input string tag);
        expect_t e;
        bit      seen = 1'b0;
        int      lat;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        lat = cyc - e0;
        compare({tag, "_done_seen"}, 64'(seen), 64'd1);
        e = sb.pop_front();
        compare({tag, "_av"},      64'(option_av), 64'(e.av));
        compare({tag, "_mss"},     64'(mss),       64'(e.mss));
        compare({tag, "_scale"},   64'(scale_wnd), 64'(e.scale));
        compare({tag, "_sacknbr"}, 64'(sack_nbr),  64'(e.nbr));
        compare({tag, "_sack0"},   sack_n0,        e.s0);
        compare({tag, "_sack1"},   sack_n1,        e.s1);
        compare({tag, "_sack2"},   sack_n2,        e.s2);
        compare({tag, "_sack3"},   sack_n3,        e.s3);
        compare({tag, "_tstamp"},  time_stp,       e.ts);
        compare({tag, "_error"},   64'(error),     64'(e.err));
        compare({tag, "_latency"}, 64'(lat),       64'(e.lat));
        @(negedge clk);
        compare({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        compare({tag, "_av"},    64'(option_av), 64'd0);
        compare({tag, "_mss"},   64'(mss),       64'd0);
        compare({tag, "_scale"}, 64'(scale_wnd), 64'd0);
        compare({tag, "_nbr"},   64'(sack_nbr),  64'd0);
        compare({tag, "_sack0"}, sack_n0,        64'd0);
        compare({tag, "_sack3"}, sack_n3,        64'd0);
        compare({tag, "_ts"},    time_stp,       64'd0);
        compare({tag, "_done"},  64'(done),      64'd0);
        compare({tag, "_error"}, 64'(error),     64'd0);
        compare({tag, "_ready"}, 64'(ready),     64'd1);
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        expect_t exp1;
        expect_t exp;
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; opt_words = 4'd0; data_option = '0;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        rst_n = 1'b1;

        // MSS, SACK-permitted, timestamps, NOP, window scale
        exp1 = mkExp(9'h11E, 16'h007B, 8'h0B, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                     64'h1234123412341234, 1'b0, 20);
        stim[0] = 32'h0204007B; stim[1] = 32'h0402080A; stim[2] = 32'h12341234;
        stim[3] = 32'h12341234; stim[4] = 32'h0103030B;
        applyStimulus(4'd5, 5, 1'b1, exp1);
        checkOutput("basic");

        // Four SACK blocks
        stim[0] = 32'h01010522;
        stim[1] = 32'h11111111; stim[2] = 32'h11111111;
        stim[3] = 32'h22222222; stim[4] = 32'h22222222;
        stim[5] = 32'h33333333; stim[6] = 32'h33333333;
        stim[7] = 32'h44444444; stim[8] = 32'h44444444;
        exp = mkExp(9'h022, 16'h0, 8'h0, 3'd4, 64'h1111111111111111, 64'h2222222222222222,
                    64'h3333333333333333, 64'h4444444444444444, 64'd0, 1'b0, 36);
        applyStimulus(4'd9, 9, 1'b1, exp);
        checkOutput("sack4");

        // MSS followed by EOL padding
        stim[0] = 32'h020405B4; stim[1] = 32'h00000000;
        exp = mkExp(9'h005, 16'h05B4, 8'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 8);
        applyStimulus(4'd2, 2, 1'b1, exp);
        checkOutput("eol");

        // Wrong MSS length
        stim[0] = 32'h02050000; stim[1] = 32'h01010101;
        exp = mkExp(9'h000, 16'h0, 8'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 8);
        applyStimulus(4'd2, 2, 1'b1, exp);
        checkOutput("badlen");

        // Timestamp option truncated by the end of the segment
        stim[0] = 32'h080A0000;
        exp = mkExp(9'h000, 16'h0, 8'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 4);
        applyStimulus(4'd1, 1, 1'b1, exp);
        checkOutput("trunc");

        // Illegal options length of zero and of eleven words
        stim[0] = 32'h020405B4;
        exp = mkExp(9'h000, 16'h0, 8'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1);
        applyStimulus(4'd0, 1, 1'b1, exp);
        checkOutput("ow0");
        applyStimulus(4'd11, 1, 1'b1, exp);
        checkOutput("ow11");

        // Segment aborted by a new start; only the second segment reports
        stim[0] = 32'h0204007B; stim[1] = 32'h0402080A;
        applyStimulus(4'd5, 2, 1'b0, exp1);
        stim[0] = 32'h020405B4; stim[1] = 32'h00000000;
        exp = mkExp(9'h005, 16'h05B4, 8'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 8);
        applyStimulus(4'd2, 2, 1'b1, exp);
        checkOutput("abort");

        // Reset while word 2 of the first scenario is in progress, then replay it
        stim[0] = 32'h0204007B; stim[1] = 32'h0402080A; stim[2] = 32'h12341234;
        stim[3] = 32'h12341234; stim[4] = 32'h0103030B;
        applyStimulus(4'd5, 3, 1'b0, exp1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        repeat (2) @(negedge clk);
        checkResetValues("midreset_hold");
        rst_n = 1'b1;
        applyStimulus(4'd5, 5, 1'b1, exp1);
        checkOutput("replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
